// File: rtl/gated_edge_counter.sv
// Purpose : counts synchronised rising edges of sig_in while one_second_gate is high and
//           latches the count as one frequency sample on every gate falling edge.
// Latency : input change to internal strobe is SYNC_STG+1 clocks; result visible one clock after g_fall.
// Backpres: data_valid/data_ack handshake; a new result overwrites an unacked one and sets sticky overrun.
//
// Ports:
//   clock, reset          sampling clock, asynchronous active-high reset
//   enable                low aborts the current window and rearms from WAIT_LOW
//   one_second_gate       counting window from the divider (asynchronous)
//   sig_in                signal under measurement (asynchronous)
//   data_out/data_valid   last completed window count and its valid flag
//   data_ack              consumer accept, clears data_valid and overrun
//   overflow              count saturated at 2^CNT_W-1, qualifies data_out
//   overrun               a result was overwritten before it was acknowledged
module gated_edge_counter #(
    parameter int CNT_W    = 32,
    parameter int SYNC_STG = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             one_second_gate,
    input  logic             sig_in,
    output logic [CNT_W-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             overflow,
    output logic             overrun
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        COUNT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [SYNC_STG-1:0] sig_sync;
    logic [SYNC_STG-1:0] gate_sync;
    logic               sig_d;
    logic               gate_d;
    logic [SYNC_STG:0]  prime_sr;
    logic               primed;
    logic               sig_s;
    logic               gate_s;
    logic               sig_edge;
    logic               g_rise;
    logic               g_fall;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   cnt_inc;
    logic               sat;
    logic               start;
    logic               latch;
    logic               abort;
    logic               ack_take;

    // Identical synchroniser + history pipelines keep gate and signal aligned in time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_sync  <= '0;
            gate_sync <= '0;
            sig_d     <= 1'b0;
            gate_d    <= 1'b0;
            prime_sr  <= '0;
        end else begin
            sig_sync  <= {sig_sync[SYNC_STG-2:0], sig_in};
            gate_sync <= {gate_sync[SYNC_STG-2:0], one_second_gate};
            sig_d     <= sig_sync[SYNC_STG-1];
            gate_d    <= gate_sync[SYNC_STG-1];
            prime_sr  <= {prime_sr[SYNC_STG-1:0], 1'b1};
        end
    end

    assign sig_s    = sig_sync[SYNC_STG-1];
    assign gate_s   = gate_sync[SYNC_STG-1];
    assign sig_edge = sig_s & ~sig_d;
    assign g_rise   = gate_s & ~gate_d;
    assign g_fall   = ~gate_s & gate_d;

    // The synchroniser clears to zero, so right after reset gate_s reads low even
    // when the gate is really high. Trusting that would arm on a fake rise and
    // measure a partial window; wait until the pipeline holds real samples.
    assign primed   = prime_sr[SYNC_STG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        latch     = 1'b0;
        abort     = 1'b0;
        if (!enable) begin
            state_nxt = WAIT_LOW;
            abort     = 1'b1;
        end else begin
            case (state)
                WAIT_LOW: if (primed && !gate_s) state_nxt = ARMED;
                ARMED: begin
                    if (g_rise) begin
                        state_nxt = COUNT;
                        start     = 1'b1;
                    end
                end
                COUNT: begin
                    if (g_fall) begin
                        state_nxt = ARMED;
                        latch     = 1'b1;
                    end
                end
                default: state_nxt = WAIT_LOW;
            endcase
        end
    end

    assign cnt_inc = counter + 1'b1;

    // An edge coincident with the gate rise is counted; one coincident with the fall is not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
            sat     <= 1'b0;
        end else if (abort) begin
            counter <= '0;
            sat     <= 1'b0;
        end else if (start) begin
            counter <= {{(CNT_W-1){1'b0}}, sig_edge};
            sat     <= 1'b0;
        end else if (state == COUNT && !g_fall && sig_edge && counter != CNT_MAX) begin
            counter <= cnt_inc;
            if (cnt_inc == CNT_MAX) sat <= 1'b1;
        end
    end

    assign ack_take = data_ack & data_valid;

    // A latch coinciding with an ack delivers the new result and leaves overrun clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            overrun    <= 1'b0;
        end else if (latch) begin
            data_out   <= counter;
            overflow   <= sat;
            data_valid <= 1'b1;
            overrun    <= ack_take ? 1'b0 : (overrun | data_valid);
        end else if (ack_take) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gated_edge_counter.sv
module tb_gated_edge_counter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        gate = 1'b1;
    logic        sig = 1'b0;
    logic        data_ack = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        overflow;
    logic        overrun;
    logic [7:0]  d8_out;
    logic        d8_valid;
    logic        d8_ovf;
    logic        d8_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    gated_edge_counter #(.CNT_W(32), .SYNC_STG(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .one_second_gate(gate), .sig_in(sig),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .overflow(overflow), .overrun(overrun)
    );

    gated_edge_counter #(.CNT_W(8), .SYNC_STG(2)) dut8 (
        .clock(clock), .reset(reset), .enable(enable), .one_second_gate(gate), .sig_in(sig),
        .data_out(d8_out), .data_valid(d8_valid), .data_ack(data_ack),
        .overflow(d8_ovf), .overrun(d8_ovr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    // Gate high for len clocks; sig rises whenever (i+phase)%per == 0.
    // fall_edge puts an extra sig rise on the same clock the gate drops.
    task automatic window(input int len, input int per, input int phase, input bit fall_edge);
        for (int i = 0; i < len; i++) begin
            gate = 1'b1;
            sig  = (((i + phase) % per) < (per / 2));
            tick();
        end
        gate = 1'b0;
        sig  = fall_edge;
        tick();
        sig = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (data_out !== 32'd0) begin n_bad++; $display("FAIL reset_data_out got %0d want 0", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_gate_high_at_release();
        reset = 1'b0;
        repeat (30) tick();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL release_gate_high_valid got %b want 0", data_valid); end
        gate = 1'b0;
        repeat (20) tick();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL partial_window_valid got %b want 0", data_valid); end
        window(100, 10, 5, 1'b0);
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL first_window_valid got %b want 1", data_valid); end
        n_cmp++; if (data_out !== 32'd10) begin n_bad++; $display("FAIL first_window_count got %0d want 10", data_out); end
        ack();
    endtask

    task automatic test_basic_count();
        window(1000, 10, 5, 1'b0);
        n_cmp++; if (data_out !== 32'd100) begin n_bad++; $display("FAIL basic_count got %0d want 100", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", data_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow got %b want 0", overflow); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun got %b want 0", overrun); end
        n_cmp++; if (d8_out !== 8'd100) begin n_bad++; $display("FAIL basic_count8 got %0d want 100", d8_out); end
        ack();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack_valid got %b want 0", data_valid); end
    endtask

    task automatic test_saturation();
        window(1200, 4, 2, 1'b0);
        n_cmp++; if (d8_out !== 8'd255) begin n_bad++; $display("FAIL sat_count8 got %0d want 255", d8_out); end
        n_cmp++; if (d8_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_overflow8 got %b want 1", d8_ovf); end
        n_cmp++; if (data_out !== 32'd300) begin n_bad++; $display("FAIL sat_count32 got %0d want 300", data_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat_overflow32 got %b want 0", overflow); end
        ack();
        n_cmp++; if (d8_valid !== 1'b0) begin n_bad++; $display("FAIL sat_ack_valid8 got %b want 0", d8_valid); end
    endtask

    task automatic test_back_to_back_overrun();
        window(500, 10, 5, 1'b0);
        n_cmp++; if (data_out !== 32'd50) begin n_bad++; $display("FAIL b2b_first_count got %0d want 50", data_out); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_first_overrun got %b want 0", overrun); end
        window(700, 10, 5, 1'b0);
        n_cmp++; if (data_out !== 32'd70) begin n_bad++; $display("FAIL b2b_second_count got %0d want 70", data_out); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun got %b want 1", overrun); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b want 1", data_valid); end
        ack();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_valid got %b want 0", data_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_overrun got %b want 0", overrun); end
        ack();
        n_cmp++; if (data_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL idle_ack got valid=%b overrun=%b want 0/0", data_valid, overrun); end
    endtask

    task automatic test_aligned_edges();
        window(200, 10, 0, 1'b1);
        n_cmp++; if (data_out !== 32'd20) begin n_bad++; $display("FAIL aligned_count got %0d want 20", data_out); end
        n_cmp++; if (d8_out !== 8'd20) begin n_bad++; $display("FAIL aligned_count8 got %0d want 20", d8_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL aligned_valid got %b want 1", data_valid); end
        ack();
    endtask

    task automatic test_enable_abort();
        for (int i = 0; i < 300; i++) begin
            gate   = 1'b1;
            sig    = (((i + 5) % 10) < 5);
            enable = !(i >= 100 && i < 105);
            tick();
        end
        gate = 1'b0;
        sig  = 1'b0;
        repeat (10) tick();
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", data_valid); end
        n_cmp++; if (data_out !== 32'd20) begin n_bad++; $display("FAIL abort_data_kept got %0d want 20", data_out); end
        window(300, 10, 5, 1'b0);
        n_cmp++; if (data_out !== 32'd30) begin n_bad++; $display("FAIL after_abort_count got %0d want 30", data_out); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL after_abort_valid got %b want 1", data_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL after_abort_overrun got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_gate_high_at_release();
        test_basic_count();
        test_saturation();
        test_back_to_back_overrun();
        test_aligned_edges();
        test_enable_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
